accum_seq_ctrl: RTL

- Sequencing controller for the channel accumulator.
- Gates N_CHANNEL upstream partial-sum beats per output pixel into the accumulator using rec_accum.
- Closes each pixel with a one-cycle stop_accum flush, then holds out_valid until the downstream consumer takes the result.
- Repeats for cfg_num_pix pixels per job; signals job completion; supports a clean abort.

---
 rtl/accum_seq_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/accum_seq_ctrl.sv
// Sequencing controller for the channel accumulator: gates N_CHANNEL beats per
// pixel, flushes the sum, holds the result until taken, repeats per job.
module accum_seq_ctrl #(
  parameter int unsigned N_CHANNEL = 8,
  parameter int unsigned CNT_WIDTH = $clog2(N_CHANNEL),
  parameter int unsigned PIX_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PIX_WIDTH-1:0] cfg_num_pix,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 rec_accum,
  output logic                 stop_accum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] ch_idx,
  output logic [PIX_WIDTH-1:0] pix_idx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_WIDTH-1:0] CH_LAST = CNT_WIDTH'(N_CHANNEL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_OUTPUT,
    S_DONE,
    S_ABORT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] ch_d;
  logic [PIX_WIDTH-1:0] pix_d;
  logic [PIX_WIDTH-1:0] num_pix_q, num_pix_d;
  logic [PIX_WIDTH-1:0] pix_last;

  assign pix_last = num_pix_q - PIX_WIDTH'(1);

  // Beat acceptance is combinational so abort can veto the beat in its own cycle.
  assign in_ready  = (state_q == S_ACCUM) && !abort;
  assign rec_accum = in_valid && in_ready;

  // Next-state, counter and job-length logic.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_idx;
    pix_d     = pix_idx;
    num_pix_d = num_pix_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_num_pix != '0) begin
            num_pix_d = cfg_num_pix;
            ch_d      = '0;
            pix_d     = '0;
            state_d   = S_ACCUM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (in_valid) begin
          if (ch_idx == CH_LAST) begin
            ch_d    = '0;
            state_d = S_FLUSH;
          end else begin
            ch_d = ch_idx + CNT_WIDTH'(1);
          end
        end
      end
      S_FLUSH: begin
        state_d = abort ? S_ABORT : S_OUTPUT;
      end
      S_OUTPUT: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (out_ready) begin
          if (pix_idx == pix_last) begin
            state_d = S_DONE;
          end else begin
            pix_d   = pix_idx + PIX_WIDTH'(1);
            state_d = S_ACCUM;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ABORT: begin
        ch_d    = '0;
        pix_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ch_idx     <= '0;
      pix_idx    <= '0;
      num_pix_q  <= '0;
      stop_accum <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_idx     <= ch_d;
      pix_idx    <= pix_d;
      num_pix_q  <= num_pix_d;
      stop_accum <= (state_d == S_FLUSH) || (state_d == S_ABORT);
      out_valid  <= (state_d == S_OUTPUT);
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
    end
  end

endmodule
